// File: rtl/mips_mc_core_if.sv
// Instruction feed channel between an instruction feeder (master) and the
// multicycle core (slave).
//   instr_valid : feeder -> core, instr holds a new instruction
//   instr       : feeder -> core, 32-bit encoded instruction
//   instr_ready : core -> feeder, core is idle and can accept
//   done        : core -> feeder, one-cycle pulse when a result is committed
interface mips_mc_core_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        done;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready,
        input  done
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready,
        output done
    );
endinterface

// File: rtl/mips_mc_core.sv
// Multicycle execution core for the CS220 MIPS subset.
// Each instruction runs IDLE -> DECODE -> EXEC -> WB -> DONE -> IDLE against
// an internal register file.
// The core sorts every instruction into one of four classes, R, I, J or bad,
// and counts how many of each it has seen.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : instr_valid/instr in, instr_ready/done out
//   jump_target         : target26 field of the last J-format instruction
//   r_cnt/i_cnt/j_cnt/bad_cnt : saturating per-format instruction counters
//   dbg_addr, dbg_data  : combinational debug read of the register file
module mips_mc_core #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_mc_core_if.slave     bus,
    output logic [25:0]       jump_target,
    output logic [CNT_W-1:0]  r_cnt,
    output logic [CNT_W-1:0]  i_cnt,
    output logic [CNT_W-1:0]  j_cnt,
    output logic [CNT_W-1:0]  bad_cnt,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int SW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        FMT_R, FMT_I, FMT_J, FMT_BAD
    } fmt_e;

    state_e             state_reg;
    fmt_e               fmt_reg;
    logic [31:0]        instr_reg;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    logic [DATA_W-1:0]  res_reg;
    logic               we_reg;
    logic [AW-1:0]      dest_reg;
    logic               ready_reg;
    logic               done_reg;

    logic [NREG-1:0][DATA_W-1:0] regs;

    // Instruction fields of the latched instruction.
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [AW-1:0] rs_idx;
    logic [AW-1:0] rt_idx;
    logic [AW-1:0] rd_idx;

    assign op     = instr_reg[31:26];
    assign func   = instr_reg[5:0];
    assign shamt  = instr_reg[10:6];
    assign imm16  = instr_reg[15:0];
    assign rs_idx = instr_reg[21 +: AW];
    assign rt_idx = instr_reg[16 +: AW];
    assign rd_idx = instr_reg[11 +: AW];

    assign bus.instr_ready = ready_reg;
    assign bus.done        = done_reg;
    assign dbg_data        = regs[dbg_addr];

    function automatic fmt_e classify(input logic [5:0] opcode);
        case (opcode)
            6'b000000:                                  return FMT_R;
            6'b001000, 6'b001100, 6'b001101, 6'b010111: return FMT_I;
            6'b000010, 6'b000011:                       return FMT_J;
            default:                                    return FMT_BAD;
        endcase
    endfunction

    // Execute stage: operands come from a_reg (rs) and b_reg (rt).
    logic [DATA_W-1:0] exec_result;
    logic              exec_we;
    logic [AW-1:0]     exec_dest;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_zx;

    assign imm_sx = DATA_W'($signed(imm16));
    assign imm_zx = DATA_W'(imm16);

    always_comb begin
        exec_result = '0;
        exec_we     = 1'b0;
        exec_dest   = rd_idx;
        case (fmt_reg)
            FMT_R: begin
                exec_we = 1'b1;
                case (func)
                    6'b100000: exec_result = a_reg + b_reg;
                    6'b100010: exec_result = a_reg - b_reg;
                    6'b100100: exec_result = a_reg & b_reg;
                    6'b100101: exec_result = a_reg | b_reg;
                    6'b000000: exec_result = b_reg << shamt;
                    6'b000010: exec_result = b_reg >> shamt;
                    6'b000100: exec_result = b_reg << a_reg[SW-1:0];
                    6'b000110: exec_result = b_reg >> a_reg[SW-1:0];
                    6'b010100: exec_result = ~(a_reg | b_reg);
                    // Unknown func still counts as R, but commits nothing.
                    default:   exec_we = 1'b0;
                endcase
            end
            FMT_I: begin
                exec_we   = 1'b1;
                exec_dest = rt_idx;
                case (op)
                    6'b001000: exec_result = a_reg + imm_sx;
                    6'b001100: exec_result = a_reg & imm_zx;
                    6'b001101: exec_result = a_reg | imm_zx;
                    default:   exec_result = a_reg ^ imm_zx;
                endcase
            end
            FMT_J: begin
                // jal clears the top register; plain j writes nothing.
                exec_we     = op[0];
                exec_dest   = AW'(NREG - 1);
                exec_result = '0;
            end
            default: ;
        endcase
    end

    // Register file. Entry 0 is hard-wired to zero, so writes to it vanish.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (state_reg == S_WB && we_reg && dest_reg == AW'(gi)) begin
                    q_reg <= res_reg;
                end
            end
            assign regs[gi] = q_reg;
        end
    end

    // Sequencer with registered handshake outputs. done is raised on the
    // edge that leaves DONE, so it is seen in the first IDLE cycle, together
    // with instr_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            fmt_reg     <= FMT_BAD;
            instr_reg   <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            we_reg      <= 1'b0;
            dest_reg    <= '0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            jump_target <= '0;
            r_cnt       <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            bad_cnt     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_reg <= bus.instr;
                        ready_reg <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    fmt_reg   <= classify(op);
                    a_reg     <= regs[rs_idx];
                    b_reg     <= regs[rt_idx];
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    res_reg   <= exec_result;
                    we_reg    <= exec_we;
                    dest_reg  <= exec_dest;
                    state_reg <= S_WB;
                end
                S_WB: begin
                    case (fmt_reg)
                        FMT_R:   if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        FMT_I:   if (i_cnt != '1) i_cnt <= i_cnt + 1'b1;
                        FMT_J: begin
                            if (j_cnt != '1) j_cnt <= j_cnt + 1'b1;
                            jump_target <= instr_reg[25:0];
                        end
                        default: if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
                    endcase
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_core.sv
module tb_mips_mc_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_mc_core_if bus();
    mips_mc_core_if bus_s();

    logic [25:0] jump_target;
    logic [7:0]  r_cnt, i_cnt, j_cnt, bad_cnt;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [25:0] s_jump_target;
    logic [1:0]  s_r_cnt, s_i_cnt, s_j_cnt, s_bad_cnt;
    logic [4:0]  s_dbg_addr;
    logic [31:0] s_dbg_data;

    mips_mc_core #(.DATA_W(32), .NREG(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .jump_target(jump_target),
        .r_cnt(r_cnt), .i_cnt(i_cnt), .j_cnt(j_cnt), .bad_cnt(bad_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mips_mc_core #(.DATA_W(32), .NREG(32), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave),
        .jump_target(s_jump_target),
        .r_cnt(s_r_cnt), .i_cnt(s_i_cnt), .j_cnt(s_j_cnt), .bad_cnt(s_bad_cnt),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present one instruction, hold it until accepted, then measure the
    // accept-to-done latency and the done pulse width.
    task automatic send(input bit to_sat, input logic [31:0] word);
        int n;
        logic rdy;
        logic dn;
        @(negedge clk);
        if (to_sat) begin bus_s.instr_valid = 1'b1; bus_s.instr = word; end
        else        begin bus.instr_valid   = 1'b1; bus.instr   = word; end
        n = 0;
        rdy = to_sat ? bus_s.instr_ready : bus.instr_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = to_sat ? bus_s.instr_ready : bus.instr_ready;
        end
        check("accept_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid   = 1'b0;
        bus_s.instr_valid = 1'b0;
        n = 0;
        dn = to_sat ? bus_s.done : bus.done;
        while (!dn && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            dn = to_sat ? bus_s.done : bus.done;
        end
        check("done_latency", 32'(n), 32'd4);
        @(posedge clk);
        #1;
        dn = to_sat ? bus_s.done : bus.done;
        check("done_width", 32'(dn), 32'd0);
        $display("instr 0x%08h committed after %0d cycles", word, n);
    endtask

    localparam int NV = 17;
    logic [31:0] vec_instr [NV] = '{
        32'h20043456, 32'h2005FFFF, 32'h00A43020, 32'h20030007,
        32'h00663004, 32'h00031842, 32'hFC859ABC, 32'h08123456,
        32'h5C859ABC, 32'h20000005, 32'h00854022, 32'h00804814,
        32'h30AAFF0F, 32'h340B8001, 32'h0080603F, 32'h201F0001,
        32'h0C000ABC
    };
    int vec_reg [NV] = '{4, 5, 6, 3, 6, 3, 5, 0, 5, 0, 8, 9, 10, 11, 12, 31, 31};
    logic [31:0] vec_exp [NV] = '{
        32'h00003456, 32'hFFFFFFFF, 32'h00003455, 32'h00000007,
        32'h001A2A80, 32'h00000003, 32'hFFFFFFFF, 32'h00000000,
        32'h0000AEEA, 32'h00000000, 32'hFFFF856C, 32'hFFFFCBA9,
        32'h0000AE0A, 32'h00008001, 32'h00000000, 32'h00000001,
        32'h00000000
    };
    logic [25:0] vec_jt [NV] = '{
        26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0123456,
        26'h0123456, 26'h0123456, 26'h0123456, 26'h0123456, 26'h0123456,
        26'h0123456, 26'h0123456, 26'h0123456, 26'h0000ABC
    };

    initial begin
        int pulses;
        bus.instr_valid   = 1'b0;
        bus.instr         = '0;
        bus_s.instr_valid = 1'b0;
        bus_s.instr       = '0;
        dbg_addr   = '0;
        s_dbg_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_jt", 32'(jump_target), 32'd0);
        check("rst_cnts", {r_cnt, i_cnt, j_cnt, bad_cnt}, 32'd0);
        dbg_addr = 5'd4;
        #1;
        check("rst_reg4", dbg_data, 32'd0);

        // Directed instruction sequence
        for (int i = 0; i < NV; i++) begin
            send(1'b0, vec_instr[i]);
            dbg_addr = 5'(vec_reg[i]);
            #1;
            check($sformatf("reg%0d_v%0d", vec_reg[i], i), dbg_data, vec_exp[i]);
            check($sformatf("jt_v%0d", i), 32'(jump_target), 32'(vec_jt[i]));
        end
        dbg_addr = 5'd4;
        #1;
        check("reg4_final", dbg_data, 32'h00003456);
        check("r_cnt", 32'(r_cnt), 32'd6);
        check("i_cnt", 32'(i_cnt), 32'd8);
        check("j_cnt", 32'(j_cnt), 32'd2);
        check("bad_cnt", 32'(bad_cnt), 32'd1);

        // Reset while addi $7,$0,9 is in EXEC
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h20070009;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_ready", 32'(bus.instr_ready), 32'd1);
        check("mid_cnts", {r_cnt, i_cnt, j_cnt, bad_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("mid_no_done", 32'(pulses), 32'd0);
        dbg_addr = 5'd7;
        #1;
        check("mid_reg7", dbg_data, 32'd0);
        check("mid_cnts_after", {r_cnt, i_cnt, j_cnt, bad_cnt}, 32'd0);
        $display("reset mid-sequence: %0d done pulses", pulses);

        // Counter saturation with CNT_W=2
        for (int k = 0; k < 5; k++) send(1'b1, 32'h20010001);
        check("sat_i_cnt", 32'(s_i_cnt), 32'd3);
        s_dbg_addr = 5'd1;
        #1;
        check("sat_reg1", s_dbg_data, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
